// File: rtl/bp_cce_inst_ram_loader.sv
// Boot loader that copies the boot ROM image into the CCE instruction RAM over the cfg link.
// Optional readback check of the written image: define BP_CCE_LOADER_VERIFY_EN.
module bp_cce_inst_ram_loader #(
    parameter int inst_ram_els_p        = 256,
    parameter int inst_width_p          = 48,
    parameter int cfg_link_addr_width_p = 16,
    parameter int cfg_link_data_width_p = 32,
    localparam int IW = (inst_ram_els_p > 1) ? $clog2(inst_ram_els_p) : 1
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    output logic                             rom_v_o,
    output logic [IW-1:0]                    rom_addr_o,
    input  logic [inst_width_p-1:0]          rom_data_i,
    output logic [cfg_link_addr_width_p-2:0] config_addr_o,
    output logic [cfg_link_data_width_p-1:0] config_data_o,
    output logic                             config_v_o,
    output logic                             config_w_o,
    input  logic                             config_ready_i,
    input  logic [cfg_link_data_width_p-1:0] config_data_i,
    input  logic                             config_v_i,
    output logic                             config_ready_o,
    output logic                             freeze_o,
    output logic                             done_o,
    output logic                             error_o
);

    localparam int AW = cfg_link_addr_width_p - 1;
    localparam int DW = cfg_link_data_width_p;
    localparam int HW = inst_width_p - cfg_link_data_width_p;
    localparam logic [IW-1:0] LAST_IDX = IW'(inst_ram_els_p - 1);

    typedef enum logic [3:0] {
        S_ROM_REQ,
        S_ROM_CAP,
        S_SEND_LO,
        S_SEND_HI,
        S_DRAIN,
        S_DONE,
        S_V_ROM_REQ,
        S_V_ROM_CAP,
        S_RD_LO,
        S_RESP_LO,
        S_RD_HI,
        S_RESP_HI
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [IW-1:0]           r_idx;
    logic [inst_width_p-1:0] r_inst;

    logic          w_rom_v;
    logic          w_hi_sel;
    logic          w_cap;
    logic          w_inc;
    logic          w_clr;
    logic          w_last;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_lo;
    logic [DW-1:0] w_hi;
    logic [DW-1:0] w_exp;

    assign w_last = (r_idx == LAST_IDX);
    assign w_lo   = r_inst[DW-1:0];

    always_comb begin
        w_hi         = '0;
        w_hi[HW-1:0] = r_inst[inst_width_p-1:DW];
    end

    assign w_exp = w_hi_sel ? w_hi : w_lo;

    // Address map: RAM select at the top bit, instruction index, then lo/hi half.
    always_comb begin
        w_addr         = '0;
        w_addr[AW-1]   = 1'b1;
        w_addr[1+:IW]  = r_idx;
        w_addr[0]      = w_hi_sel;
    end

`ifdef BP_CCE_LOADER_VERIFY_EN
    logic w_chk;
    logic r_error;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_rom_v        = 1'b0;
        w_hi_sel       = 1'b0;
        w_cap          = 1'b0;
        w_inc          = 1'b0;
        w_clr          = 1'b0;
        config_v_o     = 1'b0;
        config_w_o     = 1'b0;
        config_ready_o = 1'b0;
`ifdef BP_CCE_LOADER_VERIFY_EN
        w_chk          = 1'b0;
`endif
        unique case (r_state)
            S_ROM_REQ: begin
                w_rom_v     = 1'b1;
                w_state_nxt = S_ROM_CAP;
            end
            S_ROM_CAP: begin
                w_cap       = 1'b1;
                w_state_nxt = S_SEND_LO;
            end
            S_SEND_LO: begin
                config_v_o = 1'b1;
                config_w_o = 1'b1;
                if (config_ready_i) w_state_nxt = S_SEND_HI;
            end
            S_SEND_HI: begin
                config_v_o = 1'b1;
                config_w_o = 1'b1;
                w_hi_sel   = 1'b1;
                if (config_ready_i) begin
                    if (w_last) begin
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_inc       = 1'b1;
                        w_state_nxt = S_ROM_REQ;
                    end
                end
            end
`ifdef BP_CCE_LOADER_VERIFY_EN
            S_DRAIN: begin
                w_clr       = 1'b1;
                w_state_nxt = S_V_ROM_REQ;
            end
            S_V_ROM_REQ: begin
                w_rom_v     = 1'b1;
                w_state_nxt = S_V_ROM_CAP;
            end
            S_V_ROM_CAP: begin
                w_cap       = 1'b1;
                w_state_nxt = S_RD_LO;
            end
            S_RD_LO: begin
                config_v_o = 1'b1;
                if (config_ready_i) w_state_nxt = S_RESP_LO;
            end
            S_RESP_LO: begin
                config_ready_o = 1'b1;
                if (config_v_i) begin
                    w_chk       = 1'b1;
                    w_state_nxt = S_RD_HI;
                end
            end
            S_RD_HI: begin
                config_v_o = 1'b1;
                w_hi_sel   = 1'b1;
                if (config_ready_i) w_state_nxt = S_RESP_HI;
            end
            S_RESP_HI: begin
                config_ready_o = 1'b1;
                w_hi_sel       = 1'b1;
                if (config_v_i) begin
                    w_chk = 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_inc       = 1'b1;
                        w_state_nxt = S_V_ROM_REQ;
                    end
                end
            end
`else
            S_DRAIN: begin
                w_state_nxt = S_DONE;
            end
`endif
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_ROM_REQ;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_ROM_REQ;
            r_idx   <= '0;
            r_inst  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cap) r_inst <= rom_data_i;
            if (w_clr) r_idx <= '0;
            else if (w_inc) r_idx <= r_idx + 1'b1;
        end
    end

`ifdef BP_CCE_LOADER_VERIFY_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_error <= 1'b0;
        else if (w_chk && (config_data_i != w_exp)) r_error <= 1'b1;
    end

    assign error_o = r_error;
`else
    logic w_unused_rd;
    assign w_unused_rd = (^config_data_i) ^ config_v_i ^ (^w_exp);
    assign error_o     = 1'b0;
`endif

    // Reset gating keeps the ROM strobe low while reset is held.
    assign rom_v_o       = w_rom_v & ~reset_i;
    assign rom_addr_o    = r_idx;
    assign config_addr_o = config_v_o ? w_addr : '0;
    assign config_data_o = (config_v_o && config_w_o) ? w_exp : '0;
    assign done_o        = (r_state == S_DONE);
    assign freeze_o      = (r_state != S_DONE);

endmodule

// File: tb/tb_bp_cce_inst_ram_loader.sv
// Directed bench for bp_cce_inst_ram_loader: 4-entry and 1-entry images.
// Readback scenarios compile in when BP_CCE_LOADER_VERIFY_EN is defined.
module tb_bp_cce_inst_ram_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_rom_v;
    logic [1:0]  a_rom_addr;
    logic [47:0] a_rom_data = '0;
    logic [14:0] a_addr;
    logic [31:0] a_data;
    logic        a_v, a_w;
    logic        a_rdy = 1'b1;
    logic [31:0] a_rd_data;
    logic        a_rd_v;
    logic        a_rdy_o, a_frz, a_done, a_err;

    logic        b_rom_v;
    logic [0:0]  b_rom_addr;
    logic [47:0] b_rom_data = '0;
    logic [14:0] b_addr;
    logic [31:0] b_data;
    logic        b_v, b_w;
    logic [31:0] b_rd_data;
    logic        b_rd_v;
    logic        b_rdy_o, b_frz, b_done, b_err;

    bp_cce_inst_ram_loader #(.inst_ram_els_p(4)) dut_a (
        .clk_i(clk), .reset_i(rst),
        .rom_v_o(a_rom_v), .rom_addr_o(a_rom_addr), .rom_data_i(a_rom_data),
        .config_addr_o(a_addr), .config_data_o(a_data),
        .config_v_o(a_v), .config_w_o(a_w), .config_ready_i(a_rdy),
        .config_data_i(a_rd_data), .config_v_i(a_rd_v), .config_ready_o(a_rdy_o),
        .freeze_o(a_frz), .done_o(a_done), .error_o(a_err)
    );

    bp_cce_inst_ram_loader #(.inst_ram_els_p(1)) dut_b (
        .clk_i(clk), .reset_i(rst),
        .rom_v_o(b_rom_v), .rom_addr_o(b_rom_addr), .rom_data_i(b_rom_data),
        .config_addr_o(b_addr), .config_data_o(b_data),
        .config_v_o(b_v), .config_w_o(b_w), .config_ready_i(1'b1),
        .config_data_i(b_rd_data), .config_v_i(b_rd_v), .config_ready_o(b_rdy_o),
        .freeze_o(b_frz), .done_o(b_done), .error_o(b_err)
    );

    logic [47:0] rom [4];
    logic [14:0] exp_addr [8];
    logic [31:0] exp_data [8];

    initial begin
        rom[0] = 48'h0000_1111_2222;
        rom[1] = 48'hABCD_1234_5678;
        rom[2] = 48'h0001_DEAD_BEEF;
        rom[3] = 48'hFFFF_0000_0001;
        exp_addr = '{15'h4000, 15'h4001, 15'h4002, 15'h4003,
                     15'h4004, 15'h4005, 15'h4006, 15'h4007};
        exp_data = '{32'h1111_2222, 32'h0000_0000, 32'h1234_5678, 32'h0000_ABCD,
                     32'hDEAD_BEEF, 32'h0000_0001, 32'h0000_0001, 32'h0000_FFFF};
    end

    always @(posedge clk) if (a_rom_v) a_rom_data <= rom[a_rom_addr];
    always @(posedge clk) if (b_rom_v) b_rom_data <= rom[{1'b0, b_rom_addr}];

    int n_pass = 0;
    int n_tot  = 0;

    int cyc = 0;
    int last_xfer = 0;
    int last_rsp = 0;
    int stall_viol = 0;
    int rd_cnt = 0;
    int bad_rd = 0;
    logic p_stall = 1'b0;
    logic [14:0] p_addr = '0;
    logic [31:0] p_data = '0;
    logic p_w = 1'b0;
    logic [14:0] wq_addr [$];
    logic [31:0] wq_data [$];
    logic [14:0] bq_addr [$];
    logic [31:0] bq_data [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            p_stall <= 1'b0;
        end else begin
            if (p_stall && (a_v !== 1'b1 || a_addr !== p_addr ||
                            a_data !== p_data || a_w !== p_w))
                stall_viol <= stall_viol + 1;
            p_stall <= a_v && !a_rdy;
            p_addr  <= a_addr;
            p_data  <= a_data;
            p_w     <= a_w;
            if (a_v && a_rdy && a_w) begin
                wq_addr.push_back(a_addr);
                wq_data.push_back(a_data);
                last_xfer <= cyc + 1;
            end
            if (a_v && a_rdy && !a_w) rd_cnt <= rd_cnt + 1;
            if (a_rd_v && a_rdy_o) last_rsp <= cyc + 1;
            if (a_rdy_o || a_err) bad_rd <= bad_rd + 1;
            if (b_v && b_w) begin
                bq_addr.push_back(b_addr);
                bq_data.push_back(b_data);
            end
        end
    end

`ifdef BP_CCE_LOADER_VERIFY_EN
    logic [31:0] ram [8];
    logic        corrupt = 1'b0;
    int          rsp_dly = 0;
    logic        pend = 1'b0;
    int          wait_n = 0;
    logic [31:0] pdata = '0;

    always @(posedge clk) begin
        if (a_v && a_rdy && a_w) ram[a_addr[2:0]] <= a_data;
        if (rst) begin
            pend <= 1'b0;
        end else if (a_v && a_rdy && !a_w) begin
            pend   <= 1'b1;
            wait_n <= rsp_dly;
            pdata  <= (corrupt && a_addr[2:0] == 3'd7) ?
                      (ram[7] ^ 32'h0000_0100) : ram[a_addr[2:0]];
        end else if (pend && a_rd_v && a_rdy_o) begin
            pend <= 1'b0;
        end else if (pend && wait_n != 0) begin
            wait_n <= wait_n - 1;
        end
    end

    assign a_rd_v    = pend && (wait_n == 0);
    assign a_rd_data = pdata;
    assign b_rd_v    = b_rdy_o;
    assign b_rd_data = '0;
`else
    logic junk_v = 1'b0;
    assign a_rd_v    = junk_v;
    assign a_rd_data = 32'h0BAD_0BAD;
    assign b_rd_v    = junk_v;
    assign b_rd_data = 32'h0BAD_0BAD;
`endif

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        a_rdy = 1'b1;
        repeat (2) @(negedge clk);
        wq_addr.delete();
        wq_data.delete();
        bq_addr.delete();
        bq_data.delete();
        stall_viol = 0;
        rd_cnt     = 0;
        bad_rd     = 0;
        rst = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int n, output logic early_err);
        n = 0;
        early_err = 1'b0;
        while (a_done !== 1'b1 && n < bound) begin
            @(posedge clk);
            #1;
            n++;
            if (a_err === 1'b1 && a_done !== 1'b1) early_err = 1'b1;
        end
    endtask

    task automatic check_writes(input string tag);
        n_tot++;
        if (wq_addr.size() !== 8) begin
            $display("FAIL %s write count: got %0d want 8", tag, wq_addr.size());
        end else begin
            n_pass++;
            for (int i = 0; i < 8; i++) begin
                n_tot++;
                if (wq_addr[i] !== exp_addr[i] || wq_data[i] !== exp_data[i])
                    $display("FAIL %s write %0d: got %h/%h want %h/%h", tag, i,
                             wq_addr[i], wq_data[i], exp_addr[i], exp_data[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tot++;
        if (a_frz !== 1'b1) $display("FAIL reset freeze: got %b want 1", a_frz);
        else n_pass++;
        n_tot++;
        if ({a_done, a_rom_v, a_v, a_w, a_rdy_o, a_err} !== 6'b0)
            $display("FAIL reset flags: got %b want 000000",
                     {a_done, a_rom_v, a_v, a_w, a_rdy_o, a_err});
        else n_pass++;
        n_tot++;
        if (a_addr !== 15'h0 || a_data !== 32'h0)
            $display("FAIL reset cfg bus: got %h/%h want 0/0", a_addr, a_data);
        else n_pass++;
    endtask

    task automatic test_load_ready();
        int n;
        logic ee;
        do_reset();
        #1;
        n_tot++;
        if (a_rom_v !== 1'b1 || a_rom_addr !== 2'd0)
            $display("FAIL first rom req: got %b/%0d want 1/0", a_rom_v, a_rom_addr);
        else n_pass++;
        wait_done(200, n, ee);
        n_tot++;
        if (a_done !== 1'b1) $display("FAIL load timeout: done %b want 1", a_done);
        else n_pass++;
`ifndef BP_CCE_LOADER_VERIFY_EN
        n_tot++;
        if (n !== 17) $display("FAIL freeze fall cycle: got %0d want 17", n);
        else n_pass++;
`endif
        n_tot++;
        if (a_frz !== 1'b0 || a_v !== 1'b0)
            $display("FAIL done outputs: freeze %b v %b want 0 0", a_frz, a_v);
        else n_pass++;
        check_writes("load");
    endtask

    task automatic test_ready_random();
        int fall;
        fall = -1;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (a_done === 1'b1) begin
                fall = cyc;
                break;
            end
            a_rdy = ($urandom_range(0, 9) < 3);
`ifndef BP_CCE_LOADER_VERIFY_EN
            junk_v = 1'($urandom_range(0, 1));
`endif
        end
        a_rdy = 1'b1;
`ifndef BP_CCE_LOADER_VERIFY_EN
        junk_v = 1'b0;
`endif
        n_tot++;
        if (fall < 0) $display("FAIL random-ready timeout: done %b want 1", a_done);
        else n_pass++;
        check_writes("rand");
        n_tot++;
        if (stall_viol !== 0) $display("FAIL stall stability: got %0d want 0", stall_viol);
        else n_pass++;
`ifndef BP_CCE_LOADER_VERIFY_EN
        n_tot++;
        if (fall !== last_xfer + 1)
            $display("FAIL drain gap: fall %0d want %0d", fall, last_xfer + 1);
        else n_pass++;
        n_tot++;
        if (rd_cnt !== 0 || bad_rd !== 0)
            $display("FAIL no readback: reads %0d rdy/err %0d want 0 0", rd_cnt, bad_rd);
        else n_pass++;
`endif
    endtask

    task automatic test_reset_midload();
        int n;
        logic ee;
        logic hit;
        hit = 1'b0;
        do_reset();
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (a_v === 1'b1 && a_addr === 15'h4005) begin
                hit = 1'b1;
                break;
            end
        end
        n_tot++;
        if (!hit) $display("FAIL reach idx2 hi: got %b want 1", hit);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_tot++;
        if (a_frz !== 1'b1 || a_v !== 1'b0 || a_addr !== 15'h0)
            $display("FAIL async abort: frz %b v %b addr %h want 1 0 0", a_frz, a_v, a_addr);
        else n_pass++;
        wq_addr.delete();
        wq_data.delete();
        @(negedge clk);
        rst = 1'b0;
        wait_done(500, n, ee);
        n_tot++;
        if (a_done !== 1'b1) $display("FAIL restart timeout: done %b want 1", a_done);
        else n_pass++;
        check_writes("restart");
    endtask

    task automatic test_single();
        int n;
        n = 0;
        do_reset();
        while (b_done !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_tot++;
        if (b_done !== 1'b1) $display("FAIL els1 timeout: done %b want 1", b_done);
        else n_pass++;
`ifndef BP_CCE_LOADER_VERIFY_EN
        n_tot++;
        if (n !== 5) $display("FAIL els1 done cycle: got %0d want 5", n);
        else n_pass++;
`endif
        n_tot++;
        if (bq_addr.size() !== 2) begin
            $display("FAIL els1 write count: got %0d want 2", bq_addr.size());
        end else begin
            n_pass++;
            n_tot++;
            if (bq_addr[0] !== 15'h4000 || bq_data[0] !== 32'h1111_2222)
                $display("FAIL els1 lo: got %h/%h want 4000/11112222", bq_addr[0], bq_data[0]);
            else n_pass++;
            n_tot++;
            if (bq_addr[1] !== 15'h4001 || bq_data[1] !== 32'h0)
                $display("FAIL els1 hi: got %h/%h want 4001/00000000", bq_addr[1], bq_data[1]);
            else n_pass++;
        end
    endtask

`ifdef BP_CCE_LOADER_VERIFY_EN
    task automatic test_verify_corrupt();
        int n;
        logic ee;
        corrupt = 1'b1;
        rsp_dly = 0;
        do_reset();
        wait_done(500, n, ee);
        n_tot++;
        if (a_done !== 1'b1 || a_err !== 1'b1)
            $display("FAIL verify corrupt: done %b err %b want 1 1", a_done, a_err);
        else n_pass++;
        n_tot++;
        if (rd_cnt !== 8) $display("FAIL verify reads: got %0d want 8", rd_cnt);
        else n_pass++;
        n_tot++;
        if (ee !== 1'b0) $display("FAIL verify early error: got %b want 0", ee);
        else n_pass++;
        corrupt = 1'b0;
    endtask

    task automatic test_verify_delay();
        int n;
        logic ee;
        rsp_dly = 3;
        do_reset();
        wait_done(1000, n, ee);
        n_tot++;
        if (a_done !== 1'b1 || a_err !== 1'b0)
            $display("FAIL verify clean: done %b err %b want 1 0", a_done, a_err);
        else n_pass++;
        n_tot++;
        if (cyc !== last_rsp)
            $display("FAIL verify freeze hold: fall %0d want %0d", cyc, last_rsp);
        else n_pass++;
        rsp_dly = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_load_ready();
        test_ready_random();
        test_reset_midload();
        test_single();
`ifdef BP_CCE_LOADER_VERIFY_EN
        test_verify_corrupt();
        test_verify_delay();
`endif
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
